// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer for the dual-dispatch out-of-order core.
//
// It allocates up to two entries per cycle in program order (slot 0 is the
// older one) and takes results from WB_PORTS writeback ports. It resolves
// branches from the branch FU and retires one entry per cycle, in order, onto
// a registered commit bus.
// A mispredict flushes only the entries younger than the branch. An exception
// at the head flushes the whole buffer.
//
// Ports
//   clk, reset (async, active-low)
//   alloc_valid/alloc_rd/alloc_is_branch  -> alloc_ready, alloc_tag {tag1,tag0}
//   wb_valid/wb_tag/wb_value/wb_exc       per-port writeback, packed port-major
//   br_valid/br_tag/br_mispredict         branch resolution
//   commit_valid/tag/rd/value             registered retire bus
//   flush                                 one-cycle pulse on exception retire
//   recover_valid/recover_tag             one-cycle pulse after a mispredict
//   count, empty, full                    occupancy
module rob_multiport #(
   parameter int DEPTH    = 8,
   parameter int DATA_W   = 32,
   parameter int AREG_W   = 3,
   parameter int WB_PORTS = 2,
   localparam int TAG_W   = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   alloc_valid,
   input  logic [2*AREG_W-1:0]          alloc_rd,
   input  logic [1:0]                   alloc_is_branch,
   output logic                         alloc_ready,
   output logic [2*TAG_W-1:0]           alloc_tag,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
   input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
   input  logic [WB_PORTS-1:0]          wb_exc,
   input  logic                         br_valid,
   input  logic [TAG_W-1:0]             br_tag,
   input  logic                         br_mispredict,
   output logic                         commit_valid,
   output logic [TAG_W-1:0]             commit_tag,
   output logic [AREG_W-1:0]            commit_rd,
   output logic [DATA_W-1:0]            commit_value,
   output logic                         flush,
   output logic                         recover_valid,
   output logic [TAG_W-1:0]             recover_tag,
   output logic [TAG_W:0]               count,
   output logic                         empty,
   output logic                         full
);

   localparam int CNT_W = TAG_W + 1;

   logic [TAG_W-1:0]  head, tail;
   logic [CNT_W-1:0]  count_q;
   logic [DEPTH-1:0]  busy, done, exc, is_br;
   logic [AREG_W-1:0] rd_q    [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];

   logic              head_ready, ret_exc, ret_any, ret_commit;
   logic              br_hit, mispred;
   logic [TAG_W-1:0]  br_off;
   logic [DEPTH-1:0]  flush_mask;
   logic [TAG_W-1:0]  tag0, tag1;
   logic              do_alloc;
   logic [1:0]        alloc_en;
   logic [CNT_W-1:0]  n_alloc;
   logic [CNT_W-1:0]  count_next;
   logic [WB_PORTS-1:0] wb_ok;
   logic [TAG_W-1:0]  wb_t [WB_PORTS];

   // Retire decisions look only at the head entry as registered at cycle start.
   assign head_ready = busy[head] & done[head];
   assign ret_exc    = head_ready & exc[head];
   assign ret_any    = head_ready & ~exc[head];
   assign ret_commit = ret_any & ~is_br[head];

   // An exception retire overrides every other input in the same cycle.
   assign br_hit  = br_valid & busy[br_tag] & is_br[br_tag] & ~ret_exc;
   assign mispred = br_hit & br_mispredict;
   assign br_off  = br_tag - head;

   // An entry is younger than the branch when its distance from the head is
   // larger than the branch's distance. Only busy entries can lie in
   // [head, tail), so this also works when the buffer is full (head == tail).
   always_comb begin
      flush_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mispred && busy[i] && (TAG_W'(TAG_W'(i) - head) > br_off))
            flush_mask[i] = 1'b1;
      end
   end

   assign alloc_ready = (count_q <= CNT_W'(DEPTH - 2));
   assign tag0        = tail;
   assign tag1        = tail + TAG_W'(alloc_valid[0]);
   assign alloc_tag   = {tag1, tag0};

   assign do_alloc = alloc_ready & ~ret_exc & ~mispred;
   assign alloc_en = do_alloc ? alloc_valid : 2'b00;
   assign n_alloc  = CNT_W'(alloc_en[0]) + CNT_W'(alloc_en[1]);

   // Slots being allocated are never busy, so the busy test also drops
   // writebacks that collide with a same-cycle allocation.
   always_comb begin
      wb_ok = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_t[p]  = wb_tag[p*TAG_W +: TAG_W];
         wb_ok[p] = wb_valid[p] & busy[wb_t[p]] & ~is_br[wb_t[p]]
                  & ~flush_mask[wb_t[p]] & ~ret_exc;
      end
   end

   always_comb begin
      if (ret_exc)
         count_next = '0;
      else if (mispred)
         count_next = {1'b0, br_off} + CNT_W'(1) - CNT_W'(ret_any);
      else
         count_next = count_q + n_alloc - CNT_W'(ret_any);
   end

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head          <= '0;
         tail          <= '0;
         count_q       <= '0;
         busy          <= '0;
         done          <= '0;
         exc           <= '0;
         is_br         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]    <= '0;
            value_q[i] <= '0;
         end
         commit_valid  <= 1'b0;
         commit_tag    <= '0;
         commit_rd     <= '0;
         commit_value  <= '0;
         flush         <= 1'b0;
         recover_valid <= 1'b0;
         recover_tag   <= '0;
      end else begin
         flush         <= ret_exc;
         recover_valid <= mispred;
         if (mispred)
            recover_tag <= br_tag;

         commit_valid <= ret_commit;
         if (ret_commit) begin
            commit_tag   <= head;
            commit_rd    <= rd_q[head];
            commit_value <= value_q[head];
         end

         if (ret_exc) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            busy    <= '0;
            done    <= '0;
            exc     <= '0;
            is_br   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               rd_q[i]    <= '0;
               value_q[i] <= '0;
            end
         end else begin
            // Ascending port order: the higher-index port wins a tag collision.
            for (int p = 0; p < WB_PORTS; p++) begin
               if (wb_ok[p]) begin
                  value_q[wb_t[p]] <= wb_value[p*DATA_W +: DATA_W];
                  done[wb_t[p]]    <= 1'b1;
                  exc[wb_t[p]]     <= wb_exc[p];
               end
            end

            if (br_hit)
               done[br_tag] <= 1'b1;

            for (int i = 0; i < DEPTH; i++) begin
               if (flush_mask[i]) begin
                  busy[i]    <= 1'b0;
                  done[i]    <= 1'b0;
                  exc[i]     <= 1'b0;
                  is_br[i]   <= 1'b0;
                  rd_q[i]    <= '0;
                  value_q[i] <= '0;
               end
            end

            if (alloc_en[0]) begin
               busy[tag0]    <= 1'b1;
               done[tag0]    <= 1'b0;
               exc[tag0]     <= 1'b0;
               is_br[tag0]   <= alloc_is_branch[0];
               rd_q[tag0]    <= alloc_rd[AREG_W-1:0];
               value_q[tag0] <= '0;
            end
            if (alloc_en[1]) begin
               busy[tag1]    <= 1'b1;
               done[tag1]    <= 1'b0;
               exc[tag1]     <= 1'b0;
               is_br[tag1]   <= alloc_is_branch[1];
               rd_q[tag1]    <= alloc_rd[2*AREG_W-1:AREG_W];
               value_q[tag1] <= '0;
            end

            // Freeing the head comes last so it overrides a late writeback to it.
            if (ret_any) begin
               busy[head]  <= 1'b0;
               done[head]  <= 1'b0;
               exc[head]   <= 1'b0;
               is_br[head] <= 1'b0;
            end

            head    <= head + TAG_W'(ret_any);
            tail    <= mispred ? (br_tag + TAG_W'(1)) : (tail + n_alloc[TAG_W-1:0]);
            count_q <= count_next;
         end
      end
   end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport. It uses a vector table for the basic
// in-order commit and fill/wrap stream. Hand-written sequences cover the
// mispredict, the exception flush, the writeback port collision and the
// asynchronous reset.
module tb_rob_multiport;

   logic        clk;
   logic        reset;
   logic [1:0]  alloc_valid;
   logic [5:0]  alloc_rd;
   logic [1:0]  alloc_is_branch;
   logic        alloc_ready;
   logic [5:0]  alloc_tag;
   logic [1:0]  wb_valid;
   logic [5:0]  wb_tag;
   logic [63:0] wb_value;
   logic [1:0]  wb_exc;
   logic        br_valid;
   logic [2:0]  br_tag;
   logic        br_mispredict;
   logic        commit_valid;
   logic [2:0]  commit_tag;
   logic [2:0]  commit_rd;
   logic [31:0] commit_value;
   logic        flush;
   logic        recover_valid;
   logic [2:0]  recover_tag;
   logic [3:0]  count;
   logic        empty;
   logic        full;

   int nerr;
   int nchk;

   rob_multiport dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_exc(wb_exc),
      .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
      .commit_value(commit_value), .flush(flush),
      .recover_valid(recover_valid), .recover_tag(recover_tag),
      .count(count), .empty(empty), .full(full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  av;
      logic [2:0]  rd0;
      logic [2:0]  rd1;
      logic [1:0]  wv;
      logic [2:0]  wt0;
      logic [31:0] wd0;
      logic [2:0]  wt1;
      logic [31:0] wd1;
      logic        ecv;
      logic [2:0]  ectag;
      logic [2:0]  ecrd;
      logic [31:0] ecval;
      logic [3:0]  ecnt;
      logic [2:0]  etag0;
      logic        efull;
      logic        erdy;
   } vec_t;

   vec_t vecs [22];

   task automatic chk(input string nm, input logic [31:0] act, input integer exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr_in();
      alloc_valid     = 2'b00;
      alloc_rd        = 6'd0;
      alloc_is_branch = 2'b00;
      wb_valid        = 2'b00;
      wb_tag          = 6'd0;
      wb_value        = 64'd0;
      wb_exc          = 2'b00;
      br_valid        = 1'b0;
      br_tag          = 3'd0;
      br_mispredict   = 1'b0;
   endtask

   // One clock edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
      clr_in();
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b0;
      clr_in();
      repeat (2) @(posedge clk);
      #1;
      chk({nm, " rst count"},   32'(count), 0);
      chk({nm, " rst empty"},   32'(empty), 1);
      chk({nm, " rst ready"},   32'(alloc_ready), 1);
      chk({nm, " rst cv"},      32'(commit_valid), 0);
      chk({nm, " rst flush"},   32'(flush), 0);
      chk({nm, " rst recover"}, 32'(recover_valid), 0);
      chk({nm, " rst tag0"},    32'(alloc_tag[2:0]), 0);
      reset = 1'b1;
   endtask

   task automatic alloc(input logic [1:0] av, input logic [2:0] rd0, input logic [2:0] rd1,
                        input logic [1:0] br);
      alloc_valid     = av;
      alloc_rd        = {rd1, rd0};
      alloc_is_branch = br;
   endtask

   task automatic wb(input logic [1:0] v, input logic [2:0] t0, input logic [31:0] d0,
                     input logic [2:0] t1, input logic [31:0] d1, input logic [1:0] e);
      wb_valid = v;
      wb_tag   = {t1, t0};
      wb_value = {d1, d0};
      wb_exc   = e;
   endtask

   task automatic chk_commit(input string nm, input integer tg, input integer rd, input integer val);
      chk({nm, " cv"}, 32'(commit_valid), 1);
      if (commit_valid === 1'b1) begin
         chk({nm, " ctag"}, 32'(commit_tag), tg);
         chk({nm, " crd"},  32'(commit_rd), rd);
         chk({nm, " cval"}, commit_value, val);
      end
   endtask

   initial begin
      nerr = 0;
      nchk = 0;
      reset = 1'b0;
      clr_in();

      // av rd0 rd1 | wv wt0 wd0 wt1 wd1 | ecv ctag crd cval | cnt tag0 full rdy
      vecs[0]  = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd0,3'd0,1'b0,1'b1};
      vecs[1]  = '{2'b11,3'd1,3'd2, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd2,3'd2,1'b0,1'b1};
      vecs[2]  = '{2'b00,3'd0,3'd0, 2'b01,3'd1,32'h7,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd2,3'd2,1'b0,1'b1};
      vecs[3]  = '{2'b00,3'd0,3'd0, 2'b01,3'd0,32'h5,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd2,3'd2,1'b0,1'b1};
      vecs[4]  = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b1,3'd0,3'd1,32'h5,   4'd1,3'd2,1'b0,1'b1};
      vecs[5]  = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b1,3'd1,3'd2,32'h7,   4'd0,3'd2,1'b0,1'b1};
      vecs[6]  = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd0,3'd2,1'b0,1'b1};
      vecs[7]  = '{2'b11,3'd3,3'd4, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd2,3'd4,1'b0,1'b1};
      vecs[8]  = '{2'b11,3'd5,3'd6, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd4,3'd6,1'b0,1'b1};
      vecs[9]  = '{2'b11,3'd7,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd6,3'd0,1'b0,1'b1};
      vecs[10] = '{2'b11,3'd1,3'd2, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd8,3'd2,1'b1,1'b0};
      vecs[11] = '{2'b11,3'd5,3'd5, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd8,3'd2,1'b1,1'b0};
      vecs[12] = '{2'b00,3'd0,3'd0, 2'b11,3'd2,32'h102,3'd3,32'h103, 1'b0,3'd0,3'd0,32'h0,   4'd8,3'd2,1'b1,1'b0};
      vecs[13] = '{2'b00,3'd0,3'd0, 2'b11,3'd4,32'h104,3'd5,32'h105, 1'b1,3'd2,3'd3,32'h102, 4'd7,3'd2,1'b0,1'b0};
      vecs[14] = '{2'b00,3'd0,3'd0, 2'b11,3'd6,32'h106,3'd7,32'h107, 1'b1,3'd3,3'd4,32'h103, 4'd6,3'd2,1'b0,1'b1};
      vecs[15] = '{2'b00,3'd0,3'd0, 2'b11,3'd0,32'h100,3'd1,32'h101, 1'b1,3'd4,3'd5,32'h104, 4'd5,3'd2,1'b0,1'b1};
      vecs[16] = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b1,3'd5,3'd6,32'h105, 4'd4,3'd2,1'b0,1'b1};
      vecs[17] = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b1,3'd6,3'd7,32'h106, 4'd3,3'd2,1'b0,1'b1};
      vecs[18] = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b1,3'd7,3'd0,32'h107, 4'd2,3'd2,1'b0,1'b1};
      vecs[19] = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b1,3'd0,3'd1,32'h100, 4'd1,3'd2,1'b0,1'b1};
      vecs[20] = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b1,3'd1,3'd2,32'h101, 4'd0,3'd2,1'b0,1'b1};
      vecs[21] = '{2'b00,3'd0,3'd0, 2'b00,3'd0,32'h0,3'd0,32'h0,     1'b0,3'd0,3'd0,32'h0,   4'd0,3'd2,1'b0,1'b1};

      // In-order commit, fill to full, ignored 5th allocation, wrap-around drain.
      do_reset("tbl");
      for (int k = 0; k < 22; k++) begin
         alloc(vecs[k].av, vecs[k].rd0, vecs[k].rd1, 2'b00);
         wb(vecs[k].wv, vecs[k].wt0, vecs[k].wd0, vecs[k].wt1, vecs[k].wd1, 2'b00);
         step();
         chk($sformatf("v%0d cv", k),      32'(commit_valid), 32'(vecs[k].ecv));
         if (vecs[k].ecv) begin
            chk($sformatf("v%0d ctag", k), 32'(commit_tag), 32'(vecs[k].ectag));
            chk($sformatf("v%0d crd", k),  32'(commit_rd), 32'(vecs[k].ecrd));
            chk($sformatf("v%0d cval", k), commit_value, vecs[k].ecval);
         end
         chk($sformatf("v%0d count", k),   32'(count), 32'(vecs[k].ecnt));
         chk($sformatf("v%0d empty", k),   32'(empty), (vecs[k].ecnt == 4'd0) ? 1 : 0);
         chk($sformatf("v%0d tag0", k),    32'(alloc_tag[2:0]), 32'(vecs[k].etag0));
         chk($sformatf("v%0d full", k),    32'(full), 32'(vecs[k].efull));
         chk($sformatf("v%0d ready", k),   32'(alloc_ready), 32'(vecs[k].erdy));
         chk($sformatf("v%0d flush", k),   32'(flush), 0);
         chk($sformatf("v%0d recover", k), 32'(recover_valid), 0);
      end

      // Mispredict on a branch at tag 2 with five entries live.
      do_reset("mp");
      alloc(2'b11, 3'd1, 3'd2, 2'b00); step();
      alloc(2'b11, 3'd3, 3'd4, 2'b01); step();
      alloc(2'b01, 3'd5, 3'd0, 2'b00); step();
      chk("mp count5", 32'(count), 5);
      chk("mp tag0 5", 32'(alloc_tag[2:0]), 5);
      br_valid = 1'b1; br_tag = 3'd2; br_mispredict = 1'b1;
      alloc(2'b11, 3'd6, 3'd7, 2'b00);
      step();
      chk("mp count3",  32'(count), 3);
      chk("mp tag0 3",  32'(alloc_tag[2:0]), 3);
      chk("mp rv",      32'(recover_valid), 1);
      chk("mp rtag",    32'(recover_tag), 2);
      chk("mp cv0",     32'(commit_valid), 0);
      wb(2'b01, 3'd3, 32'h33, 3'd0, 32'h0, 2'b00);
      step();
      chk("mp rv pulse", 32'(recover_valid), 0);
      chk("mp count3b",  32'(count), 3);
      wb(2'b11, 3'd0, 32'hA, 3'd1, 32'hB, 2'b00);
      step();
      chk("mp cv idle", 32'(commit_valid), 0);
      step();
      chk_commit("mp c0", 0, 1, 32'hA);
      chk("mp count2", 32'(count), 2);
      step();
      chk_commit("mp c1", 1, 2, 32'hB);
      step();
      chk("mp br silent", 32'(commit_valid), 0);
      chk("mp count0",    32'(count), 0);
      chk("mp empty",     32'(empty), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("mp no young commit %0d", i), 32'(commit_valid), 0);
      end
      alloc(2'b01, 3'd6, 3'd0, 2'b00);
      #1;
      chk("mp next tag0", 32'(alloc_tag[2:0]), 3);
      step();
      chk("mp count1", 32'(count), 1);

      // Exception at the head with four entries live.
      do_reset("ex");
      alloc(2'b11, 3'd1, 3'd2, 2'b00); step();
      alloc(2'b11, 3'd3, 3'd4, 2'b00); step();
      chk("ex count4", 32'(count), 4);
      wb(2'b01, 3'd0, 32'h99, 3'd0, 32'h0, 2'b01);
      step();
      chk("ex count4b", 32'(count), 4);
      chk("ex flush0",  32'(flush), 0);
      alloc(2'b11, 3'd5, 3'd6, 2'b00);
      step();
      chk("ex flush1", 32'(flush), 1);
      chk("ex cv0",    32'(commit_valid), 0);
      chk("ex count0", 32'(count), 0);
      chk("ex empty",  32'(empty), 1);
      chk("ex tag0",   32'(alloc_tag[2:0]), 0);
      step();
      chk("ex flush pulse", 32'(flush), 0);
      chk("ex cv0b",        32'(commit_valid), 0);
      alloc(2'b01, 3'd7, 3'd0, 2'b00);
      #1;
      chk("ex new tag0", 32'(alloc_tag[2:0]), 0);
      chk("ex new tag1", 32'(alloc_tag[5:3]), 1);
      step();
      chk("ex count1", 32'(count), 1);
      chk("ex tail1",  32'(alloc_tag[2:0]), 1);

      // Both ports hit tag 1; a writeback to a free tag is dropped.
      do_reset("wp");
      alloc(2'b11, 3'd1, 3'd2, 2'b00); step();
      wb(2'b11, 3'd1, 32'h11, 3'd1, 32'h22, 2'b00); step();
      wb(2'b11, 3'd5, 32'h55, 3'd0, 32'h10, 2'b00); step();
      chk("wp count2", 32'(count), 2);
      chk("wp cv0",    32'(commit_valid), 0);
      step();
      chk_commit("wp c0", 0, 1, 32'h10);
      step();
      chk_commit("wp c1", 1, 2, 32'h22);
      chk("wp count0", 32'(count), 0);
      step();
      chk("wp no free commit", 32'(commit_valid), 0);

      // Asynchronous reset in the middle of a commit stream.
      do_reset("ar");
      alloc(2'b11, 3'd1, 3'd2, 2'b00); step();
      alloc(2'b11, 3'd3, 3'd4, 2'b00); step();
      wb(2'b11, 3'd0, 32'h1, 3'd1, 32'h2, 2'b00); step();
      wb(2'b11, 3'd2, 32'h3, 3'd3, 32'h4, 2'b00); step();
      chk_commit("ar c0", 0, 1, 32'h1);
      step();
      chk_commit("ar c1", 1, 2, 32'h2);
      #2;
      reset = 1'b0;
      #1;
      chk("ar cv",    32'(commit_valid), 0);
      chk("ar ctag",  32'(commit_tag), 0);
      chk("ar cval",  commit_value, 0);
      chk("ar count", 32'(count), 0);
      chk("ar empty", 32'(empty), 1);
      chk("ar ready", 32'(alloc_ready), 1);
      chk("ar tag0",  32'(alloc_tag[2:0]), 0);
      @(negedge clk);
      reset = 1'b1;
      alloc(2'b01, 3'd5, 3'd0, 2'b00);
      #1;
      chk("ar restart tag0", 32'(alloc_tag[2:0]), 0);
      step();
      chk("ar count1", 32'(count), 1);
      chk("ar tail1",  32'(alloc_tag[2:0]), 1);
      chk("ar cv idle", 32'(commit_valid), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
